// File: rtl/dsp_reg_master.sv
// Command-driven initiator for the DSP register bus: single/burst writes and reads,
// plus status polling with timeout, answering on a valid/ready response stream.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a command, cmd_ready high
// S_WRITE    | taking write beats, one register write per wd handshake
// S_RD_ADDR  | launching a bus read at beat_addr
// S_RD_WAIT  | waiting RD_LATENCY cycles, then sampling rdata
// S_RD_RESP  | presenting read/poll data until rsp_ready
// S_WR_ACK   | presenting the single write acknowledge
// S_ERR_RESP | presenting the error response for a reserved op
module dsp_reg_master #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int RD_LATENCY   = 1,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WRITE    = 3'd1;
  localparam logic [2:0] S_RD_ADDR  = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RD_RESP  = 3'd4;
  localparam logic [2:0] S_WR_ACK   = 3'd5;
  localparam logic [2:0] S_ERR_RESP = 3'd6;

  logic [2:0]            state;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [PW-1:0]         poll_cnt;
  logic                  lat_q;
  logic                  rd_sample;
  logic                  poll_hit;
  logic                  poll_last;

  assign cmd_ready = (state == S_IDLE);
  assign wd_ready  = (state == S_WRITE);
  assign rsp_valid = (state == S_RD_RESP) || (state == S_WR_ACK) || (state == S_ERR_RESP);
  assign busy      = (state != S_IDLE);

  // With zero latency rdata is sampled in the same cycle addr becomes visible.
  assign rd_sample = (RD_LATENCY == 0) || lat_q;
  assign poll_hit  = |(rdata & mask_q);
  assign poll_last = (poll_cnt == PW'(POLL_TIMEOUT - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_WRITE;
      beat_addr <= '0;
      beat_cnt  <= '0;
      mask_q    <= '0;
      poll_cnt  <= '0;
      lat_q     <= 1'b0;
      addr      <= '0;
      write_en  <= 1'b0;
      wdata     <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      write_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            beat_addr <= cmd_addr;
            beat_cnt  <= cmd_len;
            mask_q    <= cmd_mask;
            poll_cnt  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b1;
            rsp_err   <= (cmd_op == 2'b11);
            case (cmd_op)
              OP_WRITE: state <= S_WRITE;
              OP_READ,
              OP_POLL:  state <= S_RD_ADDR;
              default:  state <= S_ERR_RESP;
            endcase
          end
        end

        S_WRITE: begin
          if (wd_valid) begin
            addr      <= beat_addr;
            wdata     <= wd_data;
            write_en  <= 1'b1;
            beat_addr <= beat_addr + ADDR_WIDTH'(1);
            if (beat_cnt == '0) state <= S_WR_ACK;
            else                beat_cnt <= beat_cnt - ADDR_WIDTH'(1);
          end
        end

        S_WR_ACK, S_ERR_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end

        S_RD_ADDR: begin
          addr  <= beat_addr;
          lat_q <= 1'b0;
          state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (!rd_sample) begin
            lat_q <= 1'b1;
          end else begin
            rsp_data <= rdata;
            if (op_q == OP_POLL) begin
              if (poll_hit) begin
                rsp_err  <= 1'b0;
                rsp_last <= 1'b1;
                state    <= S_RD_RESP;
              end else if (poll_last) begin
                rsp_err  <= 1'b1;
                rsp_last <= 1'b1;
                state    <= S_RD_RESP;
              end else begin
                poll_cnt <= poll_cnt + PW'(1);
                state    <= S_RD_ADDR;
              end
            end else begin
              rsp_err  <= 1'b0;
              rsp_last <= (beat_cnt == '0);
              state    <= S_RD_RESP;
            end
          end
        end

        S_RD_RESP: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state <= S_IDLE;
            end else begin
              beat_addr <= beat_addr + ADDR_WIDTH'(1);
              beat_cnt  <= beat_cnt - ADDR_WIDTH'(1);
              state     <= S_RD_ADDR;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_reg_master.sv
// Directed bench for dsp_reg_master: instance 0 has RD_LATENCY=1/POLL_TIMEOUT=1024,
// instance 1 has RD_LATENCY=0/POLL_TIMEOUT=4; each drives its own register model.
module tb_dsp_reg_master;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk;
  logic          arst_n;
  logic          cmd_valid [2];
  logic          cmd_ready [2];
  logic [1:0]    cmd_op    [2];
  logic [AW-1:0] cmd_addr  [2];
  logic [AW-1:0] cmd_len   [2];
  logic [DW-1:0] cmd_mask  [2];
  logic          wd_valid  [2];
  logic          wd_ready  [2];
  logic [DW-1:0] wd_data   [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          rsp_last  [2];
  logic          rsp_err   [2];
  logic          busy      [2];
  logic [AW-1:0] addr      [2];
  logic          write_en  [2];
  logic [DW-1:0] wdata     [2];
  logic [DW-1:0] rdata     [2];

  logic [DW-1:0] mem [2][64];
  logic [DW-1:0] rd_q;
  logic          poll_force;
  logic [DW-1:0] poll_word;
  logic [AW-1:0] wl_addr [2][256];
  logic [DW-1:0] wl_data [2][256];
  int            wl_cyc  [2][256];
  int            wl_n    [2] = '{0, 0};
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dsp_reg_master #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .RD_LATENCY  ((g == 0) ? 1 : 0),
      .POLL_TIMEOUT((g == 0) ? 1024 : 4)
    ) u_dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_op   (cmd_op[g]),
      .cmd_addr (cmd_addr[g]),
      .cmd_len  (cmd_len[g]),
      .cmd_mask (cmd_mask[g]),
      .wd_valid (wd_valid[g]),
      .wd_ready (wd_ready[g]),
      .wd_data  (wd_data[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data (rsp_data[g]),
      .rsp_last (rsp_last[g]),
      .rsp_err  (rsp_err[g]),
      .busy     (busy[g]),
      .addr     (addr[g]),
      .write_en (write_en[g]),
      .wdata    (wdata[g]),
      .rdata    (rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register responder models plus a log of every write strobe seen on each bus.
  assign rdata[0] = poll_force ? poll_word : rd_q;
  assign rdata[1] = mem[1][addr[1]];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_q <= mem[0][addr[0]];
    for (int d = 0; d < 2; d++) begin
      if (!arst_n) begin
        for (int i = 0; i < 64; i++) mem[d][i] <= '0;
      end else if (write_en[d]) begin
        mem[d][addr[d]]        <= wdata[d];
        wl_addr[d][wl_n[d]]    <= addr[d];
        wl_data[d][wl_n[d]]    <= wdata[d];
        wl_cyc[d][wl_n[d]]     <= cyc;
        wl_n[d]                <= wl_n[d] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_cmd(input int d, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [AW-1:0] len, input logic [DW-1:0] m, output int t0);
    int n;
    n = 0;
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_addr[d]  = a;
    cmd_len[d]   = len;
    cmd_mask[d]  = m;
    while (!cmd_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready[d], 1);
    t0 = cyc;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
  endtask

  task automatic send_beats(input int d, input int nb, input logic [DW-1:0] base);
    int n;
    for (int i = 0; i < nb; i++) begin
      n = 0;
      wd_valid[d] = 1'b1;
      wd_data[d]  = base + DW'(i);
      while (!wd_ready[d] && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("wd_accept", wd_ready[d], 1);
      @(negedge clk);
    end
    wd_valid[d] = 1'b0;
  endtask

  task automatic get_rsp(input int d, output logic [DW-1:0] data, output logic last,
                         output logic err, output int tc);
    int n;
    n = 0;
    while (!rsp_valid[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", rsp_valid[d], 1);
    data = rsp_data[d];
    last = rsp_last[d];
    err  = rsp_err[d];
    tc   = cyc;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, tc, w0, n;
    logic [DW-1:0] rd;
    logic rl, re;

    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_op[d] = '0; cmd_addr[d] = '0; cmd_len[d] = '0;
      cmd_mask[d] = '0; wd_valid[d] = 1'b0; wd_data[d] = '0; rsp_ready[d] = 1'b0;
    end
    poll_force = 1'b0;
    poll_word  = '0;
    arst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_cmd_ready", cmd_ready[0], 1);
    check("rst_wd_ready", wd_ready[0], 0);
    check("rst_write_en", write_en[0], 0);
    check("rst_addr", addr[0], 0);
    check("rst_rsp_valid", rsp_valid[0], 0);
    arst_n = 1'b1;
    @(negedge clk);

    // Single write
    w0 = wl_n[0];
    send_cmd(0, 2'b00, 6'd0, 6'd0, '0, t0);
    send_beats(0, 1, 16'h0025);
    get_rsp(0, rd, rl, re, tc);
    check("w1_count", wl_n[0] - w0, 1);
    check("w1_addr", wl_addr[0][w0], 0);
    check("w1_data", wl_data[0][w0], 16'h0025);
    check("w1_cyc", wl_cyc[0][w0] - t0, 2);
    check("w1_ack_cyc", tc - t0, 2);
    check("w1_ack_data", rd, 0);
    check("w1_ack_last", rl, 1);
    check("w1_ack_err", re, 0);

    // Burst write wrapping past address 63
    w0 = wl_n[0];
    send_cmd(0, 2'b00, 6'd62, 6'd3, '0, t0);
    send_beats(0, 4, 16'h0001);
    get_rsp(0, rd, rl, re, tc);
    check("wrap_count", wl_n[0] - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check("wrap_addr", wl_addr[0][w0 + i], (62 + i) % 64);
      check("wrap_data", wl_data[0][w0 + i], 1 + i);
      check("wrap_cyc", wl_cyc[0][w0 + i] - t0, 2 + i);
    end
    check("wrap_ack_cyc", tc - t0, 5);
    check("wrap_ack_last", rl, 1);
    for (int i = 0; i < 3; i++) begin
      check("wrap_single_ack", rsp_valid[0], 0);
      @(negedge clk);
    end

    // Burst read with a 5-cycle stall on beat 2
    send_cmd(0, 2'b00, 6'd33, 6'd2, '0, t0);
    send_beats(0, 3, 16'hA5A0);
    get_rsp(0, rd, rl, re, tc);
    send_cmd(0, 2'b01, 6'd33, 6'd2, '0, t0);
    get_rsp(0, rd, rl, re, tc);
    check("rd_b1_cyc", tc - t0, 4);
    check("rd_b1_data", rd, 16'hA5A0);
    check("rd_b1_last", rl, 0);
    check("rd_b1_err", re, 0);
    n = 0;
    while (!rsp_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_b2_valid", rsp_valid[0], 1);
    check("rd_b2_cyc", cyc - t0, 8);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", rsp_valid[0], 1);
      check("stall_data", rsp_data[0], 16'hA5A1);
      check("stall_addr", addr[0], 34);
      check("stall_last", rsp_last[0], 0);
      @(negedge clk);
    end
    get_rsp(0, rd, rl, re, tc);
    check("rd_b2_data", rd, 16'hA5A1);
    get_rsp(0, rd, rl, re, tc);
    check("rd_b3_cyc", tc - t0, 17);
    check("rd_b3_data", rd, 16'hA5A2);
    check("rd_b3_last", rl, 1);
    check("rd_done_busy", busy[0], 0);

    // Poll: seven misses (bits outside the mask set), then a hit on read 8
    poll_force = 1'b1;
    poll_word  = 16'hFFFE;
    send_cmd(0, 2'b10, 6'd5, 6'd0, 16'h0001, t0);
    n = 0;
    while (cyc < t0 + 22 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("poll_no_early_rsp", rsp_valid[0], 0);
    check("poll_addr", addr[0], 5);
    poll_word = 16'h0001;
    get_rsp(0, rd, rl, re, tc);
    check("poll_cyc", tc - t0, 25);
    check("poll_data", rd, 1);
    check("poll_err", re, 0);
    check("poll_last", rl, 1);
    poll_force = 1'b0;

    // Reserved op
    w0 = wl_n[0];
    send_cmd(0, 2'b11, 6'd20, 6'd0, '0, t0);
    get_rsp(0, rd, rl, re, tc);
    check("rsv_cyc", tc - t0, 1);
    check("rsv_err", re, 1);
    check("rsv_last", rl, 1);
    check("rsv_data", rd, 0);
    check("rsv_no_write", wl_n[0] - w0, 0);
    check("rsv_addr_idle", addr[0], 5);

    // Poll timeout on the 4-read instance, rdata always 0
    send_cmd(1, 2'b10, 6'd7, 6'd0, 16'hFFFF, t0);
    get_rsp(1, rd, rl, re, tc);
    check("pto_cyc", tc - t0, 9);
    check("pto_err", re, 1);
    check("pto_data", rd, 0);
    check("pto_last", rl, 1);

    // Zero-latency burst read
    send_cmd(1, 2'b00, 6'd10, 6'd1, '0, t0);
    send_beats(1, 2, 16'h1234);
    get_rsp(1, rd, rl, re, tc);
    send_cmd(1, 2'b01, 6'd10, 6'd1, '0, t0);
    get_rsp(1, rd, rl, re, tc);
    check("l0_b1_cyc", tc - t0, 3);
    check("l0_b1_data", rd, 16'h1234);
    check("l0_b1_last", rl, 0);
    get_rsp(1, rd, rl, re, tc);
    check("l0_b2_cyc", tc - t0, 6);
    check("l0_b2_data", rd, 16'h1235);
    check("l0_b2_last", rl, 1);

    // Reset at write beat 3 of 8
    send_cmd(0, 2'b00, 6'd40, 6'd7, '0, t0);
    send_beats(0, 3, 16'h0100);
    check("mid_we_before", write_en[0], 1);
    wd_valid[0] = 1'b1;
    wd_data[0]  = 16'h0103;
    arst_n      = 1'b0;
    #1;
    check("mid_write_en", write_en[0], 0);
    check("mid_addr", addr[0], 0);
    check("mid_wdata", wdata[0], 0);
    check("mid_rsp_valid", rsp_valid[0], 0);
    check("mid_rsp_data", rsp_data[0], 0);
    check("mid_rsp_err", rsp_err[0], 0);
    check("mid_busy", busy[0], 0);
    check("mid_wd_ready", wd_ready[0], 0);
    @(negedge clk);
    @(negedge clk);
    wd_valid[0] = 1'b0;
    arst_n      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_no_ack", rsp_valid[0], 0);
      @(negedge clk);
    end
    w0 = wl_n[0];
    send_cmd(0, 2'b00, 6'd40, 6'd1, '0, t0);
    send_beats(0, 2, 16'h0200);
    get_rsp(0, rd, rl, re, tc);
    check("post_rst_ack_cyc", tc - t0, 3);
    check("post_rst_ack_err", re, 0);
    check("post_rst_count", wl_n[0] - w0, 2);
    check("post_rst_addr0", wl_addr[0][w0], 40);
    check("post_rst_addr1", wl_addr[0][w0 + 1], 41);
    check("post_rst_data1", wl_data[0][w0 + 1], 16'h0201);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
